// File: rtl/sign_magnitude_pkg.sv
// Shared types and constants for the sign-magnitude converter pipeline.
// The optional macro SM_SATURATE_EN is consumed by sign_magnitude_pipe.
package sign_magnitude_pkg;

  // Widest datapath the shared payload struct can carry.
  localparam int SM_MAX_W = 64;

  typedef enum logic {
    MODE_TC2SM = 1'b0,
    MODE_SM2TC = 1'b1
  } sm_mode_e;

  // Payload held in stage 1. Data fields are sized for SM_MAX_W; a
  // narrower pipe uses only the low W bits.
  typedef struct packed {
    sm_mode_e              mode;
    logic [SM_MAX_W-1:0]   data;
    logic                  sign;
    logic [SM_MAX_W-1:0]   negated;
    logic                  ovf;
  } sm_stage_t;

  // Most-negative two's-complement pattern of a w-bit word.
  function automatic logic [SM_MAX_W-1:0] most_neg(input int w);
    return {{(SM_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

  // Largest positive two's-complement value of a w-bit word.
  function automatic logic [SM_MAX_W-1:0] max_pos(input int w);
    return most_neg(w) - {{(SM_MAX_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sign_magnitude_pipe_sm_negate.sv
// Combinational W-bit negate and the SM2TC range check that feed stage 1.
module sm_negate
  import sign_magnitude_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] data,
  input  logic         sign,
  output logic [W-1:0] negated,
  output logic         ovf
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Two's-complement negation; negating zero yields zero, which also
  // canonicalises negative zero.
  always_comb begin
    negated = ~data + ONE;
  end

  // A positive magnitude must stay below 2^(W-1); a negative one may
  // reach exactly 2^(W-1).
  always_comb begin
    ovf = sign ? (data[W-1] && (|data[W-2:0])) : data[W-1];
  end

endmodule

// File: rtl/sign_magnitude_pipe.sv
// Two-stage valid/ready converter between two's-complement and
// sign-magnitude. Define SM_SATURATE_EN to clamp SM2TC results that
// overflow; otherwise the wrapped result is emitted with out_ovf set.
module sign_magnitude_pipe
  import sign_magnitude_pkg::*;
#(
  parameter int Word_Length = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic [Word_Length-1:0] in_data,
  input  logic                   in_sign,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Word_Length-1:0] out_data,
  output logic                   out_sign,
  output logic                   out_ovf
);

  localparam int W = Word_Length;
  localparam logic [SM_MAX_W-1:0] MOST_NEG_FULL = most_neg(W);
  localparam logic [SM_MAX_W-1:0] MAX_POS_FULL  = max_pos(W);

  logic            s1_valid_reg;
  sm_stage_t       s1_reg;
  sm_stage_t       s1_next;
  logic            s2_valid_reg;
  logic [W-1:0]    out_data_reg;
  logic            out_sign_reg;
  logic            out_ovf_reg;
  logic [W-1:0]    res_data_next;
  logic            res_sign_next;
  logic            res_ovf_next;
  logic [W-1:0]    neg_w;
  logic            ovf_w;
  logic            s2_load;
  logic            in_fire;

  sm_negate #(.W(W)) u_negate (
    .data    (in_data),
    .sign    (in_sign),
    .negated (neg_w),
    .ovf     (ovf_w)
  );

  // Upper payload bits of a narrow pipe are constant zero and never read.
  generate
    if (W < SM_MAX_W) begin : g_pad
      logic pad_unused;
      assign pad_unused = ^{s1_reg.data[SM_MAX_W-1:W], s1_reg.negated[SM_MAX_W-1:W]};
    end
  endgenerate

  // Ready chain: stage 2 refills when empty or draining; stage 1 follows.
  always_comb begin
    s2_load  = !s2_valid_reg || out_ready;
    in_ready = !s1_valid_reg || s2_load;
    in_fire  = in_valid && in_ready;
  end

  // Stage-1 payload: the sign that governs negation depends on the mode.
  always_comb begin
    s1_next              = '0;
    s1_next.mode         = sm_mode_e'(mode);
    s1_next.data[W-1:0]  = in_data;
    s1_next.negated[W-1:0] = neg_w;
    s1_next.sign         = (mode == MODE_SM2TC) ? in_sign : in_data[W-1];
    s1_next.ovf          = (mode == MODE_SM2TC) && ovf_w;
  end

  // Stage-2 result selection, optional saturation and output sign.
  always_comb begin
    res_data_next = s1_reg.sign ? s1_reg.negated[W-1:0] : s1_reg.data[W-1:0];
`ifdef SM_SATURATE_EN
    if (s1_reg.ovf) begin
      res_data_next = s1_reg.sign ? MOST_NEG_FULL[W-1:0] : MAX_POS_FULL[W-1:0];
    end
`endif
    res_sign_next = (s1_reg.mode == MODE_SM2TC) ? res_data_next[W-1] : s1_reg.sign;
    res_ovf_next  = s1_reg.ovf;
  end

  // Stage 1 register: capture on transfer, empty when stage 2 takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
      s1_reg       <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_reg <= 1'b1;
        s1_reg       <= s1_next;
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

  // Stage 2 register: outputs change only when a real entry moves in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_reg <= 1'b0;
      out_data_reg <= '0;
      out_sign_reg <= 1'b0;
      out_ovf_reg  <= 1'b0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg <= res_data_next;
        out_sign_reg <= res_sign_next;
        out_ovf_reg  <= res_ovf_next;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sign  = out_sign_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_sign_magnitude_pipe.sv
// Directed self-checking bench for sign_magnitude_pipe at W = 8.
// Expected overflow results follow SM_SATURATE_EN when it is defined.
module tb_sign_magnitude_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         mode = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_sign = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_sign;
  logic         out_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sign_magnitude_pipe #(.Word_Length(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .in_data   (in_data),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sign  (out_sign),
    .out_ovf   (out_ovf)
  );

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_data, out_sign, out_ovf} !== 11'b0) begin
      failures++;
      $display("FAIL reset_state got valid=%b data=%h sign=%b ovf=%b exp all zero",
               out_valid, out_data, out_sign, out_ovf);
    end
    in_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_tc2sm();
    logic [W-1:0] vin [0:2];
    logic [W-1:0] vexp [0:2];
    logic         sexp [0:2];
    vin  = '{8'hF6, 8'h0A, 8'h80};
    vexp = '{8'h0A, 8'h0A, 8'h80};
    sexp = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      mode = 1'b0; in_sign = 1'b0; in_data = vin[i]; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL tc2sm_early[%0d] got valid=%b exp=0", i, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_data, out_sign, out_ovf} !== {1'b1, vexp[i], sexp[i], 1'b0}) begin
        failures++;
        $display("FAIL tc2sm[%0d] in=%h got valid=%b data=%h sign=%b ovf=%b exp valid=1 data=%h sign=%b ovf=0",
                 i, vin[i], out_valid, out_data, out_sign, out_ovf, vexp[i], sexp[i]);
      end
    end
  endtask

  task automatic test_sm2tc();
    logic [W-1:0] vin [0:2];
    logic         vsg [0:2];
    logic [W-1:0] vexp [0:2];
    logic         sexp [0:2];
    vin  = '{8'h80, 8'h0A, 8'h00};
    vsg  = '{1'b1, 1'b1, 1'b1};
    vexp = '{8'h80, 8'hF6, 8'h00};
    sexp = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      mode = 1'b1; in_sign = vsg[i]; in_data = vin[i]; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL sm2tc_early[%0d] got valid=%b exp=0", i, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_data, out_sign, out_ovf} !== {1'b1, vexp[i], sexp[i], 1'b0}) begin
        failures++;
        $display("FAIL sm2tc[%0d] in=%b/%h got valid=%b data=%h sign=%b ovf=%b exp valid=1 data=%h sign=%b ovf=0",
                 i, vsg[i], vin[i], out_valid, out_data, out_sign, out_ovf, vexp[i], sexp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] vin [0:1];
    logic         vsg [0:1];
    logic [W-1:0] vexp [0:1];
    logic         sexp [0:1];
    vin = '{8'h80, 8'h81};
    vsg = '{1'b0, 1'b1};
`ifdef SM_SATURATE_EN
    vexp = '{8'h7F, 8'h80};
    sexp = '{1'b0, 1'b1};
`else
    vexp = '{8'h80, 8'h7F};
    sexp = '{1'b1, 1'b0};
`endif
    for (int i = 0; i < 2; i++) begin
      mode = 1'b1; in_sign = vsg[i]; in_data = vin[i]; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_data, out_sign, out_ovf} !== {1'b1, vexp[i], sexp[i], 1'b1}) begin
        failures++;
        $display("FAIL overflow[%0d] in=%b/%h got valid=%b data=%h sign=%b ovf=%b exp valid=1 data=%h sign=%b ovf=1",
                 i, vsg[i], vin[i], out_valid, out_data, out_sign, out_ovf, vexp[i], sexp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int rcvd = 0;
    int occ = 0;
    int cyc = 0;
    int full_seen = 0;
    logic [W-1:0] held = '0;
    logic held_v = 1'b0;
    logic exp_rdy;
    mode = 1'b0; in_sign = 1'b0;
    while (rcvd < 6 && cyc < 40) begin
      in_valid  = (sent < 6);
      in_data   = 8'(sent + 1);
      out_ready = !(cyc >= 3 && cyc <= 6);
      @(negedge clk);
      if (held_v && out_valid) begin
        checks++;
        if (out_data !== held) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d got=%h exp=%h", cyc, out_data, held);
        end
      end
      held_v = out_valid && !out_ready;
      held   = out_data;
      exp_rdy = !(occ == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
      end
      if (!in_ready) full_seen++;
      if (out_valid && out_ready) begin
        checks++;
        if ({out_data, out_sign, out_ovf} !== {8'(rcvd + 1), 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL bp_order idx=%0d got data=%h sign=%b ovf=%b exp data=%h sign=0 ovf=0",
                   rcvd, out_data, out_sign, out_ovf, 8'(rcvd + 1));
        end
        rcvd++;
        occ--;
      end
      if (in_valid && in_ready) begin
        sent++;
        occ++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (rcvd != 6) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=6", rcvd);
    end
    checks++;
    if (full_seen == 0) begin
      failures++;
      $display("FAIL bp_full_stall got in_ready-low cycles=%0d exp>0", full_seen);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_extra got valid=%b data=%h exp valid=0", out_valid, out_data);
    end
  endtask

  task automatic test_mode_interleave();
    logic         vm   [0:5];
    logic         vsg  [0:5];
    logic [W-1:0] vin  [0:5];
    logic [W-1:0] vexp [0:5];
    logic         sexp [0:5];
    int idx = 0;
    int got = 0;
    vm   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vsg  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vin  = '{8'hF6, 8'h0A, 8'h05, 8'h05, 8'h80, 8'h00};
    vexp = '{8'h0A, 8'hF6, 8'h05, 8'h05, 8'h80, 8'h00};
    sexp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16 && got < 6; cyc++) begin
      in_valid = (idx < 6);
      if (idx < 6) begin
        mode = vm[idx]; in_sign = vsg[idx]; in_data = vin[idx];
      end
      @(negedge clk);
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL mix_in_ready cyc=%0d got=%b exp=1", cyc, in_ready);
        end
        idx++;
      end
      if (out_valid) begin
        checks++;
        if (cyc != 2 + got || {out_data, out_sign, out_ovf} !== {vexp[got], sexp[got], 1'b0}) begin
          failures++;
          $display("FAIL mix[%0d] cyc=%0d got data=%h sign=%b ovf=%b exp cyc=%0d data=%h sign=%b ovf=0",
                   got, cyc, out_data, out_sign, out_ovf, 2 + got, vexp[got], sexp[got]);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 6) begin
      failures++;
      $display("FAIL mix_count got=%0d exp=6", got);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; mode = 1'b0; in_sign = 1'b0;
    in_data = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'h22;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_fill got valid=%b in_ready=%b exp valid=1 in_ready=0", out_valid, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_sign, out_ovf} !== 11'b0) begin
      failures++;
      $display("FAIL rst_async got valid=%b data=%h sign=%b ovf=%b exp all zero",
               out_valid, out_data, out_sign, out_ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    mode = 1'b1; in_sign = 1'b1; in_data = 8'h0A; in_valid = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_leftover got valid=%b data=%h exp valid=0", out_valid, out_data);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_early got valid=%b exp=0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_data, out_sign, out_ovf} !== {1'b1, 8'hF6, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL rst_first got valid=%b data=%h sign=%b ovf=%b exp valid=1 data=f6 sign=1 ovf=0",
               out_valid, out_data, out_sign, out_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_tc2sm();
    drain();
    test_sm2tc();
    drain();
    test_overflow();
    drain();
    test_backpressure();
    drain();
    test_mode_interleave();
    drain();
    test_reset_midstream();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
